branch_target_buffer: RTL and testbench

- Small direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits upstream of the next-PC selection logic. The IF stage looks it up combinationally with PCF; it supplies a predicted-taken flag and target for next-PC selection.
- The EX stage writes back resolved branch outcomes and receives a mispredict indication.
- Also keeps two 32-bit performance counters: branches resolved and mispredicts.

---
 rtl/branch_target_buffer_pkg.sv | 26 ++
 rtl/branch_target_buffer.sv | 96 +++++++++
 tb/tb_branch_target_buffer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: direction counter
// encodings, the saturating counter update, and the default table size.
package branch_target_buffer_pkg;

    localparam int unsigned ENTRIES_DEFAULT = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Saturating step toward the resolved outcome.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nxt = ctr_t'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// combinational fetch lookup, EX-stage update and resolve/mispredict counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_e;
    logic             hit_f;
    logic             hit_e;
    logic             pred_taken_f;
    logic             mispred;

    // Instruction alignment bits carry no information for the table.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[31:IDX_W+2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[31:IDX_W+2];

    always_comb begin
        hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        pred_taken_f = hit_f && ctr_q[idx_f][1];
        mispred      = UpdateE &&
                       ((PredTakenE != BranchE) ||
                        (BranchE && PredTakenE && (PredTargetE != BrTargetE)));
    end

    assign PredTakenF  = pred_taken_f;
    assign PredTargetF = pred_taken_f ? target_q[idx_f] : '0;
    assign MispredE    = mispred;
    assign BranchCnt   = branch_cnt_q;
    assign MispredCnt  = mispred_cnt_q;

    // Not-taken misses leave the table alone so cold branches never allocate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= SNT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (UpdateE) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (hit_e) begin
                    ctr_q[idx_e] <= ctr_next(ctr_q[idx_e], BranchE);
                    if (BranchE) target_q[idx_e] <= BrTargetE;
                end else if (BranchE) begin
                    valid_q[idx_e]  <= 1'b1;
                    tag_q[idx_e]    <= tag_e;
                    target_q[idx_e] <= BrTargetE;
                    ctr_q[idx_e]    <= WT;
                end
            end
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer against a table-level
// behavioural model with directed scenarios and randomized traffic.
module tb_branch_target_buffer;

    localparam int ENT = 16;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredE;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    int checks;
    int failures;

    // Reference model state
    logic        m_valid  [ENT];
    logic [31:0] m_tag    [ENT];
    logic [31:0] m_target [ENT];
    int          m_ctr    [ENT];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    branch_target_buffer #(.ENTRIES(ENT)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .UpdateE(UpdateE), .PCE(PCE),
        .BranchE(BranchE), .BrTargetE(BrTargetE), .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE), .MispredE(MispredE),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int i;
        i = midx(pc);
        return m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] pc);
        return m_taken(pc) ? m_target[midx(pc)] : 32'h0;
    endfunction

    function automatic logic m_mis(input logic upd, input logic br, input logic [31:0] tgt,
                                   input logic pt, input logic [31:0] ptgt);
        if (!upd) return 1'b0;
        if (pt != br) return 1'b1;
        return br && (ptgt != tgt);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'h0; m_target[i] = 32'h0; m_ctr[i] = 0;
        end
        m_bcnt = 32'h0;
        m_mcnt = 32'h0;
    endfunction

    function automatic void m_apply(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        int i;
        i = midx(pc);
        if (m_hit(pc)) begin
            if (br) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (br) begin
            m_valid[i] = 1'b1; m_tag[i] = pc / (4 * ENT); m_target[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    // Advance one clock edge, mirroring whatever update is being presented.
    task automatic tick();
        logic        upd, br, mis;
        logic [31:0] pc, tgt;
        upd = UpdateE && !rst;
        br  = BranchE;
        pc  = PCE;
        tgt = BrTargetE;
        mis = m_mis(UpdateE, BranchE, BrTargetE, PredTakenE, PredTargetE) && !rst;
        @(posedge clk);
        #1;
        if (upd) begin
            m_apply(pc, br, tgt);
            m_bcnt = m_bcnt + 32'd1;
        end
        if (mis) m_mcnt = m_mcnt + 32'd1;
    endtask

    task automatic present(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        UpdateE     = 1'b1;
        PCE         = pc;
        BranchE     = br;
        BrTargetE   = tgt;
        PredTakenE  = m_taken(pc);
        PredTargetE = m_tgt(pc);
    endtask

    task automatic idle_update();
        UpdateE = 1'b0; BranchE = 1'b0; PredTakenE = 1'b0; PredTargetE = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; PCF = 32'h0; PCE = 32'h0; BrTargetE = 32'h0;
        idle_update();
        m_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        PCF = 32'h0000_0040;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL cold_taken got=%0h exp=0", PredTakenF); end
        checks++; if (PredTargetF !== 32'h0) begin failures++; $display("FAIL cold_target got=%0h exp=0", PredTargetF); end
        checks++; if (BranchCnt !== 32'h0) begin failures++; $display("FAIL cold_bcnt got=%0h exp=0", BranchCnt); end
        checks++; if (MispredCnt !== 32'h0) begin failures++; $display("FAIL cold_mcnt got=%0h exp=0", MispredCnt); end
        checks++; if (MispredE !== 1'b0) begin failures++; $display("FAIL cold_mispred got=%0h exp=0", MispredE); end
    endtask

    task automatic test_allocate();
        present(32'h40, 1'b1, 32'h100);
        #1;
        checks++; if (MispredE !== 1'b1) begin failures++; $display("FAIL alloc_mispred got=%0h exp=1", MispredE); end
        tick();
        idle_update();
        PCF = 32'h40;
        #1;
        checks++; if (PredTakenF !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%0h exp=1", PredTakenF); end
        checks++; if (PredTargetF !== 32'h100) begin failures++; $display("FAIL alloc_target got=%0h exp=100", PredTargetF); end
        checks++; if (BranchCnt !== 32'd1) begin failures++; $display("FAIL alloc_bcnt got=%0h exp=1", BranchCnt); end
        checks++; if (MispredCnt !== 32'd1) begin failures++; $display("FAIL alloc_mcnt got=%0h exp=1", MispredCnt); end
    endtask

    task automatic test_hysteresis();
        // outcome sequence: saturate high, walk down past SNT, climb back up
        logic seq [10];
        logic exp_taken [10];
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_taken = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        PCF = 32'h40;
        for (int i = 0; i < 10; i++) begin
            present(32'h40, seq[i], 32'h100);
            #1;
            checks++; if (MispredE !== m_mis(1'b1, seq[i], 32'h100, PredTakenE, PredTargetE)) begin
                failures++; $display("FAIL hyst_mispred step=%0d got=%0h exp=%0h", i, MispredE, ~MispredE); end
            tick();
            idle_update();
            #1;
            checks++; if (PredTakenF !== exp_taken[i] || PredTakenF !== m_taken(32'h40)) begin
                failures++; $display("FAIL hyst_taken step=%0d got=%0h exp=%0h", i, PredTakenF, exp_taken[i]); end
        end
        checks++; if (BranchCnt !== m_bcnt) begin failures++; $display("FAIL hyst_bcnt got=%0h exp=%0h", BranchCnt, m_bcnt); end
        checks++; if (MispredCnt !== m_mcnt) begin failures++; $display("FAIL hyst_mcnt got=%0h exp=%0h", MispredCnt, m_mcnt); end
    endtask

    task automatic test_not_taken_miss();
        logic [31:0] b0, m0;
        b0 = BranchCnt; m0 = MispredCnt;
        present(32'h80, 1'b0, 32'h0);
        #1;
        checks++; if (MispredE !== 1'b0) begin failures++; $display("FAIL ntmiss_mispred got=%0h exp=0", MispredE); end
        tick();
        idle_update();
        PCF = 32'h80;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL ntmiss_taken got=%0h exp=0", PredTakenF); end
        checks++; if (BranchCnt !== b0 + 32'd1) begin failures++; $display("FAIL ntmiss_bcnt got=%0h exp=%0h", BranchCnt, b0 + 32'd1); end
        checks++; if (MispredCnt !== m0) begin failures++; $display("FAIL ntmiss_mcnt got=%0h exp=%0h", MispredCnt, m0); end
    endtask

    task automatic test_alias();
        present(32'h440, 1'b1, 32'h200);
        tick();
        idle_update();
        PCF = 32'h440;
        #1;
        checks++; if (PredTakenF !== 1'b1) begin failures++; $display("FAIL alias_new_taken got=%0h exp=1", PredTakenF); end
        checks++; if (PredTargetF !== 32'h200) begin failures++; $display("FAIL alias_new_target got=%0h exp=200", PredTargetF); end
        PCF = 32'h40;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL alias_old_taken got=%0h exp=0", PredTakenF); end
    endtask

    task automatic test_same_cycle_and_reset();
        present(32'h40, 1'b1, 32'h300);
        tick();
        PCF = 32'h40;
        present(32'h40, 1'b1, 32'h340);
        #1;
        checks++; if (PredTargetF !== 32'h300) begin failures++; $display("FAIL same_pre_target got=%0h exp=300", PredTargetF); end
        tick();
        idle_update();
        #1;
        checks++; if (PredTargetF !== 32'h340) begin failures++; $display("FAIL same_post_target got=%0h exp=340", PredTargetF); end
        rst = 1'b1;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0h exp=0", PredTakenF); end
        checks++; if (PredTargetF !== 32'h0) begin failures++; $display("FAIL rst_target got=%0h exp=0", PredTargetF); end
        checks++; if (BranchCnt !== 32'h0) begin failures++; $display("FAIL rst_bcnt got=%0h exp=0", BranchCnt); end
        checks++; if (MispredCnt !== 32'h0) begin failures++; $display("FAIL rst_mcnt got=%0h exp=0", MispredCnt); end
        m_reset();
        UpdateE = 1'b1; PCE = 32'h40; BranchE = 1'b1; BrTargetE = 32'h500;
        PredTakenE = 1'b0; PredTargetE = 32'h0;
        #1;
        checks++; if (MispredE !== 1'b1) begin failures++; $display("FAIL rst_mispred got=%0h exp=1", MispredE); end
        tick();
        checks++; if (BranchCnt !== 32'h0) begin failures++; $display("FAIL rst_hold_bcnt got=%0h exp=0", BranchCnt); end
        idle_update();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL rst_release_taken got=%0h exp=0", PredTakenF); end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] tgts [4];
        tgts = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        for (int n = 0; n < 400; n++) begin
            PCF = ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENT - 1) << 2) | $urandom_range(0, 3);
            pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENT - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                present(pc, 1'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)]);
                if ($urandom_range(0, 7) == 0) begin
                    PredTakenE  = 1'($urandom_range(0, 1));
                    PredTargetE = tgts[$urandom_range(0, 3)];
                end
            end else begin
                idle_update();
                PCE = pc;
            end
            #1;
            checks++; if (PredTakenF !== m_taken(PCF)) begin
                failures++; $display("FAIL rnd_taken n=%0d pc=%0h got=%0h exp=%0h", n, PCF, PredTakenF, m_taken(PCF)); end
            checks++; if (PredTargetF !== m_tgt(PCF)) begin
                failures++; $display("FAIL rnd_target n=%0d pc=%0h got=%0h exp=%0h", n, PCF, PredTargetF, m_tgt(PCF)); end
            checks++; if (MispredE !== m_mis(UpdateE, BranchE, BrTargetE, PredTakenE, PredTargetE)) begin
                failures++; $display("FAIL rnd_mispred n=%0d got=%0h exp=%0h", n, MispredE, ~MispredE); end
            tick();
            checks++; if (BranchCnt !== m_bcnt || MispredCnt !== m_mcnt) begin
                failures++; $display("FAIL rnd_counts n=%0d got=%0h/%0h exp=%0h/%0h", n, BranchCnt, MispredCnt, m_bcnt, m_mcnt); end
        end
        idle_update();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_not_taken_miss();
        test_alias();
        test_same_cycle_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
